// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, instruction memory and decode.
// The master modport is the sequencer; the slave modport is the imem/core side.
interface fetch_sequencer_if;
    logic        stall;
    logic        exc;
    logic        jump;
    logic [25:0] instr_index;
    logic        branch;
    logic        zero;
    logic [31:0] sign_imm;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;

    modport master (
        input  stall, exc, jump, instr_index,
        input  branch, zero, sign_imm,
        input  imem_ack, imem_rdata,
        output imem_req, imem_addr,
        output instr, instr_valid, instr_pc, pc_plus4
    );

    modport slave (
        output stall, exc, jump, instr_index,
        output branch, zero, sign_imm,
        output imem_ack, imem_rdata,
        input  imem_req, imem_addr,
        input  instr, instr_valid, instr_pc, pc_plus4
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencing and single-outstanding imem fetch for the MIPS core.
// Optional delay-slot redirect behaviour: define BRANCH_DELAY_SLOT_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0380
) (
    input  logic               i_clock,
    input  logic               i_reset,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_kill;

    logic        w_consume;
    logic        w_redirect;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_br_tgt;
    logic [31:0] w_redir_tgt;
    logic [31:0] w_seq_pc;

    logic        w_capture;
    logic        w_drop;
    logic        w_load_addr;
    logic [31:0] w_new_addr;
    logic        w_set_kill;
    logic        w_clr_kill;

    assign w_consume   = r_valid & ~bus.stall;
    assign w_redirect  = bus.jump | (bus.branch & bus.zero);
    assign w_jump_tgt  = {r_pc4[31:28], bus.instr_index, 2'b00};
    // Shifting drops sign_imm[31:30]; the word offset wraps mod 2^32.
    assign w_br_tgt    = r_pc4 + (bus.sign_imm << 2);
    assign w_redir_tgt = bus.jump ? w_jump_tgt : w_br_tgt;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        r_pending;
    logic [31:0] r_ptarget;

    // A redirect first fetches the slot at pc_plus4; the target follows it.
    assign w_seq_pc = r_pending ? r_ptarget : r_pc4;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= 1'b0;
            r_ptarget <= '0;
        end else if (bus.exc) begin
            r_pending <= 1'b0;
        end else if (r_state == S_HOLD && w_consume) begin
            if (r_pending) begin
                r_pending <= 1'b0;
            end else if (w_redirect) begin
                r_pending <= 1'b1;
                r_ptarget <= w_redir_tgt;
            end
        end
    end
`else
    assign w_seq_pc = w_redirect ? w_redir_tgt : r_pc4;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        w_load_addr = 1'b0;
        w_new_addr  = r_addr;
        w_set_kill  = 1'b0;
        w_clr_kill  = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                w_next = S_FETCH;
                if (bus.exc) begin
                    w_load_addr = 1'b1;
                    w_new_addr  = EXC_VECTOR;
                end
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    w_clr_kill = 1'b1;
                    // A killed fetch completes but its data is discarded.
                    if (r_kill | bus.exc) begin
                        w_load_addr = 1'b1;
                        w_new_addr  = EXC_VECTOR;
                    end else begin
                        w_capture = 1'b1;
                        w_next    = S_HOLD;
                    end
                end else if (bus.exc) begin
                    w_set_kill = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.exc) begin
                    w_drop      = 1'b1;
                    w_load_addr = 1'b1;
                    w_new_addr  = EXC_VECTOR;
                    w_next      = S_FETCH;
                end else if (w_consume) begin
                    w_drop      = 1'b1;
                    w_load_addr = 1'b1;
                    w_new_addr  = w_seq_pc;
                    w_next      = S_FETCH;
                end
            end
            default: begin
                w_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_addr  <= RESET_PC;
            r_instr <= '0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
            r_kill  <= 1'b0;
        end else begin
            if (w_load_addr) begin
                r_addr <= w_new_addr;
            end
            if (w_capture) begin
                r_instr <= bus.imem_rdata;
                r_pc    <= r_addr;
                r_pc4   <= r_addr + 32'd4;
                r_valid <= 1'b1;
            end else if (w_drop) begin
                r_valid <= 1'b0;
            end
            if (w_set_kill) begin
                r_kill <= 1'b1;
            end else if (w_clr_kill) begin
                r_kill <= 1'b0;
            end
        end
    end

    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.imem_addr   = r_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_valid;
    assign bus.instr_pc    = r_pc;
    assign bus.pc_plus4    = r_pc4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: table of redirect vectors plus exception/reset sequences.
// Expected fetch addresses are queued at consume time and checked when imem_req appears.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if bus();

    fetch_sequencer dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic        j;
        logic [25:0] idx;
        logic        b;
        logic        z;
        logic [31:0] si;
        logic [31:0] nxt;
        int          waitc;
    } vec_t;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] q_addr[$];
    logic [31:0] last_addr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic pop_chk(input string name);
        logic [31:0] e;
        if (q_addr.size() == 0) begin
            n_chk++;
            $display("FAIL %s: scoreboard empty, got addr %h expected none",
                     name, bus.imem_addr);
        end else begin
            e = q_addr.pop_front();
            last_addr = e;
            check(name, bus.imem_addr, e);
        end
    endtask

    task automatic await_req(input string name);
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            step();
            n++;
        end
        n_chk++;
        if (bus.imem_req) n_pass++;
        else $display("FAIL %s: got no imem_req expected req within 20 cycles", name);
    endtask

    task automatic serve(input string name, input int waitc);
        logic [31:0] d;
        await_req(name);
        pop_chk({name, "_addr"});
        d = 32'h5A00_0000 ^ last_addr;
        for (int k = 0; k < waitc; k++) begin
            step();
            check({name, "_req_hold"}, {31'd0, bus.imem_req}, 32'd1);
            check({name, "_addr_hold"}, bus.imem_addr, last_addr);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = d;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check({name, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
        check({name, "_instr"}, bus.instr, d);
        check({name, "_pc"}, bus.instr_pc, last_addr);
        check({name, "_pc4"}, bus.pc_plus4, last_addr + 32'd4);
    endtask

    task automatic consume(input logic j, input logic [25:0] idx,
                           input logic b, input logic z,
                           input logic [31:0] si, input logic [31:0] nxt);
        bus.stall       = 1'b0;
        bus.jump        = j;
        bus.instr_index = idx;
        bus.branch      = b;
        bus.zero        = z;
        bus.sign_imm    = si;
        q_addr.push_back(nxt);
        step();
        bus.stall       = 1'b1;
        bus.jump        = 1'b0;
        bus.instr_index = '0;
        bus.branch      = 1'b0;
        bus.zero        = 1'b0;
        bus.sign_imm    = '0;
        check("consume_valid_drop", {31'd0, bus.instr_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        tbl[0]  = '{1'b0, 26'h0,       1'b0, 1'b0, 32'h0,         32'h0000_0004, 0};
        tbl[1]  = '{1'b0, 26'h0,       1'b0, 1'b0, 32'h0,         32'h0000_0008, 2};
        tbl[2]  = '{1'b1, 26'h0100004, 1'b0, 1'b0, 32'h0,         32'h0040_0010, 1};
        tbl[3]  = '{1'b1, 26'h0100008, 1'b0, 1'b0, 32'h0,         32'h0040_0020, 0};
        tbl[4]  = '{1'b0, 26'h0,       1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0040_0004, 1};
        tbl[5]  = '{1'b0, 26'h0,       1'b1, 1'b0, 32'h5,         32'h0040_0008, 0};
        tbl[6]  = '{1'b1, 26'h40,      1'b1, 1'b1, 32'h3,         32'h0000_0100, 0};
        tbl[7]  = '{1'b0, 26'h0,       1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_00FC, 2};
        tbl[8]  = '{1'b0, 26'h0,       1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0100, 0};
        tbl[9]  = '{1'b0, 26'h0,       1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0104, 1};
        tbl[10] = '{1'b1, 26'h3FFFFFF, 1'b0, 1'b0, 32'h0,         32'h0FFF_FFFC, 0};
        tbl[11] = '{1'b0, 26'h0,       1'b0, 1'b0, 32'h0,         32'h1000_0000, 0};
        tbl[12] = '{1'b1, 26'h10,      1'b0, 1'b0, 32'h0,         32'h1000_0040, 0};
        tbl[13] = '{1'b0, 26'h0,       1'b1, 1'b1, 32'hFBFF_FFF0, 32'h0000_0004, 1};

        bus.stall       = 1'b1;
        bus.exc         = 1'b0;
        bus.jump        = 1'b0;
        bus.instr_index = '0;
        bus.branch      = 1'b0;
        bus.zero        = 1'b0;
        bus.sign_imm    = '0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        rst = 1'b1;
        repeat (3) step();
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_pc", bus.instr_pc, 32'h0);
        check("rst_pc4", bus.pc_plus4, 32'h0);
        rst = 1'b0;
        check("boot_no_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        check("boot_req_1cyc", {31'd0, bus.imem_req}, 32'd1);
        q_addr.push_back(32'h0);
        serve("boot", 0);

`ifdef BRANCH_DELAY_SLOT_EN
        consume(1'b1, 26'h10, 1'b0, 1'b0, 32'h0, 32'h0000_0004);
        serve("slot", 0);
        consume(1'b1, 26'h20, 1'b0, 1'b0, 32'h0, 32'h0000_0040);
        serve("target", 1);
        consume(1'b1, 26'h30, 1'b0, 1'b0, 32'h0, 32'h0000_0044);
        serve("slot2", 0);
        bus.exc = 1'b1;
        step();
        bus.exc = 1'b0;
        check("slot_exc_valid", {31'd0, bus.instr_valid}, 32'd0);
        q_addr.push_back(32'h0000_0380);
        serve("slot_exc", 0);
        consume(1'b0, 26'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0384);
        serve("after_exc", 0);
`else
        for (int i = 0; i < 14; i++) begin
            consume(tbl[i].j, tbl[i].idx, tbl[i].b, tbl[i].z,
                    tbl[i].si, tbl[i].nxt);
            serve($sformatf("vec%0d", i), tbl[i].waitc);
        end

        bus.jump        = 1'b1;
        bus.instr_index = 26'h3;
        bus.branch      = 1'b1;
        bus.zero        = 1'b1;
        step();
        step();
        check("stall_hold_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("stall_hold_req", {31'd0, bus.imem_req}, 32'd0);
        bus.jump        = 1'b0;
        bus.instr_index = '0;
        bus.branch      = 1'b0;
        bus.zero        = 1'b0;
        consume(1'b0, 26'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0008);

        await_req("excw");
        pop_chk("excw_addr");
        bus.exc = 1'b1;
        step();
        bus.exc = 1'b0;
        check("excw_req_held", {31'd0, bus.imem_req}, 32'd1);
        check("excw_addr_held", bus.imem_addr, 32'h0000_0008);
        step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check("excw_squash", {31'd0, bus.instr_valid}, 32'd0);
        step();
        check("excw_squash2", {31'd0, bus.instr_valid}, 32'd0);
        q_addr.push_back(32'h0000_0380);
        serve("excw_vec", 0);

        consume(1'b0, 26'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0384);
        await_req("exca");
        pop_chk("exca_addr");
        bus.exc        = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_0001;
        step();
        bus.exc        = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check("exca_squash", {31'd0, bus.instr_valid}, 32'd0);
        q_addr.push_back(32'h0000_0380);
        serve("exca_vec", 1);

        bus.exc = 1'b1;
        step();
        bus.exc = 1'b0;
        check("exch_valid_fall", {31'd0, bus.instr_valid}, 32'd0);
        q_addr.push_back(32'h0000_0380);
        serve("exch_vec", 0);
`endif

        consume(1'b0, 26'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0384);
        await_req("rstm");
        pop_chk("rstm_addr");
        rst = 1'b1;
        #1;
        check("rstm_req", {31'd0, bus.imem_req}, 32'd0);
        check("rstm_addr0", bus.imem_addr, 32'h0);
        check("rstm_valid", {31'd0, bus.instr_valid}, 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_0002;
        step();
        step();
        rst = 1'b0;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check("rstm_late_ack", {31'd0, bus.instr_valid}, 32'd0);
        q_addr.push_back(32'h0);
        serve("reboot", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
